// File: rtl/doodle_pkg.sv
// doodle_pkg: shared game states, keycodes and screen geometry for the Doodle Jump display path
package doodle_pkg;
   typedef enum logic [2:0] {START = 3'd0, RISE = 3'd1, FALL = 3'd2, DEAD = 3'd3} state_t;
   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_D = 8'h07;
   localparam logic [7:0] KEY_SPACE = 8'h2C;
   localparam int SCR_W = 640;
   localparam int SCR_H = 480;
   localparam logic [9:0] START_X = 10'd320;
   localparam logic [9:0] START_Y = 10'd400;
endpackage

// File: rtl/land_check.sv
// land_check: finds the lowest-index platform whose top the player's bottom edge crosses this frame
module land_check #(
   parameter int NPLAT = 4,
   parameter logic [9:0] SIZE = 10'd4
) (
   input  logic [9:0] y,
   input  logic signed [10:0] yn,
   input  logic signed [10:0] xn,
   input  logic [10*NPLAT-1:0] plat_x,
   input  logic [10*NPLAT-1:0] plat_y,
   input  logic [9:0] plat_s,
   output logic hit,
   output logic [9:0] hit_top
);
   localparam logic signed [10:0] SZ = 11'(SIZE);
   logic signed [10:0] top, dx, reach, ps;
   always_comb begin
      hit = 1'b0;
      hit_top = '0;
      top = '0;
      dx = '0;
      ps = $signed({1'b0, plat_s});
      reach = ps + SZ;
      // scanning high to low lets the lowest index overwrite and win
      for (int i = NPLAT - 1; i >= 0; i--) begin
         top = $signed({1'b0, plat_y[10*i +: 10]}) - ps;
         dx = xn - $signed({1'b0, plat_x[10*i +: 10]});
         if ($signed({1'b0, y}) + SZ <= top && yn + SZ >= top && (dx[10] ? -dx : dx) <= reach) begin
            hit = 1'b1;
            hit_top = 10'(top - SZ);
         end
      end
   end
endmodule

// File: rtl/doodle_motion.sv
// doodle_motion: per-frame player physics (steer, gravity, landing, wrap, death) feeding color_mapper
module doodle_motion
   import doodle_pkg::*;
#(
   parameter int NPLAT = 4,
   parameter logic [9:0] SIZE = 10'd4,
   parameter int X_STEP = 2,
   parameter int JUMP_V = 12,
   parameter int MAX_FALL = 8
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic frame_clk,
   input  logic [7:0] keycode,
   input  logic [10*NPLAT-1:0] PlatX,
   input  logic [10*NPLAT-1:0] PlatY,
   input  logic [9:0] PlatS,
   output logic [9:0] BallX,
   output logic [9:0] BallY,
   output logic [9:0] Ball_size,
   output logic [2:0] outstate
);
   localparam logic signed [10:0] SZ = 11'(SIZE);
   localparam logic signed [10:0] XST = 11'(X_STEP);
   localparam logic signed [10:0] XMAX = 11'(SCR_W - 1) - SZ;
   localparam logic signed [10:0] YMAX = 11'(SCR_H - 1);
   localparam logic signed [7:0] JV = 8'(JUMP_V);
   localparam logic signed [7:0] MF = 8'(MAX_FALL);
   state_t state;
   logic [9:0] x, y;
   logic signed [7:0] vy, vi, vn;
   logic signed [10:0] xc, yc, xs, xw, yn;
   logic fc_d, tick, hit;
   logic [9:0] hit_top;
   assign tick = frame_clk & ~fc_d;
   assign BallX = x;
   assign BallY = y;
   assign Ball_size = SIZE;
   assign outstate = state;
   always_comb begin
      xc = $signed({1'b0, x});
      yc = $signed({1'b0, y});
      xs = keycode == KEY_A ? xc - XST : keycode == KEY_D ? xc + XST : xc;
      xw = xs < SZ ? XMAX : xs > XMAX ? SZ : xs;
      yn = yc + 11'(vy);
      vi = vy + 8'sd1;
      vn = vi > MF ? MF : vi;
   end
   land_check #(.NPLAT(NPLAT), .SIZE(SIZE)) u_land (
      .y(y),
      .yn(yn),
      .xn(xw),
      .plat_x(PlatX),
      .plat_y(PlatY),
      .plat_s(PlatS),
      .hit(hit),
      .hit_top(hit_top)
   );
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         fc_d <= 1'b0;
         x <= START_X;
         y <= START_Y;
         vy <= '0;
         state <= START;
      end else begin
         fc_d <= frame_clk;
         if (tick) begin
            case (state)
               START: if (keycode == KEY_SPACE) begin
                  vy <= -JV;
                  state <= RISE;
               end
               RISE: begin
                  x <= xw[9:0];
                  y <= yn[9:0];
                  vy <= vn;
                  if (!vn[7]) state <= FALL;
               end
               FALL: begin
                  x <= xw[9:0];
                  y <= hit ? hit_top : yn[9:0];
                  vy <= hit ? -JV : vn;
                  // a landing outranks falling off the bottom in the same frame
                  if (hit) state <= RISE;
                  else if (yn - SZ > YMAX) state <= DEAD;
               end
               default: if (keycode == KEY_SPACE) begin
                  x <= START_X;
                  y <= START_Y;
                  vy <= '0;
                  state <= START;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_doodle_motion.sv
// tb_doodle_motion: scoreboard bench comparing doodle_motion against a frame-level game model
module tb_doodle_motion;
   logic clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0;
   logic [7:0] keycode = '0;
   logic [39:0] plat_x = '0, plat_y = '0;
   logic [9:0] plat_s = '0;
   logic [9:0] ball_x, ball_y, ball_size;
   logic [2:0] outstate;
   typedef struct {int x; int y; int s;} exp_t;
   exp_t q[$];
   int n_chk = 0, n_fail = 0;
   int mx = 320, my = 400, mvy = 0, ms = 0;
   int px[4], py[4], ps = 0;
   logic due = 1'b0, fc_prev = 1'b0;

   doodle_motion dut (
      .Clk(clk),
      .Reset_n(Reset_n),
      .frame_clk(frame_clk),
      .keycode(keycode),
      .PlatX(plat_x),
      .PlatY(plat_y),
      .PlatS(plat_s),
      .BallX(ball_x),
      .BallY(ball_y),
      .Ball_size(ball_size),
      .outstate(outstate)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // game model: one call per frame, written from the play rules with plain integers
   task automatic model_tick(input int key);
      int nx, ny, nvy, top, dx;
      bit landed;
      if (ms == 0) begin
         if (key == 'h2C) begin mvy = -12; ms = 1; end
      end else if (ms == 3) begin
         if (key == 'h2C) begin mx = 320; my = 400; mvy = 0; ms = 0; end
      end else begin
         nx = mx + (key == 'h04 ? -2 : key == 'h07 ? 2 : 0);
         if (nx < 4) nx = 635;
         else if (nx > 635) nx = 4;
         ny = my + mvy;
         nvy = (mvy + 1 > 8) ? 8 : mvy + 1;
         landed = 0;
         if (ms == 2)
            for (int i = 0; i < 4 && !landed; i++) begin
               top = py[i] - ps;
               dx = nx - px[i];
               if (dx < 0) dx = -dx;
               if (my + 4 <= top && ny + 4 >= top && dx <= 4 + ps) begin
                  landed = 1;
                  ny = top - 4;
                  nvy = -12;
               end
            end
         if (landed) ms = 1;
         else if (ms == 1 && nvy >= 0) ms = 2;
         else if (ms == 2 && ny - 4 > 479) ms = 3;
         mx = nx;
         my = ny;
         mvy = nvy;
      end
      q.push_back('{mx, my, ms});
   endtask

   task automatic model_reset();
      mx = 320; my = 400; mvy = 0; ms = 0;
   endtask

   task automatic apply_plat();
      for (int i = 0; i < 4; i++) begin
         plat_x[10*i +: 10] = 10'(px[i]);
         plat_y[10*i +: 10] = 10'(py[i]);
      end
      plat_s = 10'(ps);
   endtask

   task automatic null_plat();
      for (int i = 0; i < 4; i++) begin px[i] = 0; py[i] = 0; end
      ps = 0;
      apply_plat();
   endtask

   // one frame: frame_clk high for 'hold' cycles, then noise on keycode between frames
   task automatic frame(input int key, input int hold);
      @(negedge clk);
      keycode = 8'(key);
      frame_clk = 1'b1;
      model_tick(key);
      repeat (hold) @(negedge clk);
      frame_clk = 1'b0;
      keycode = 8'($urandom);
      repeat (2) @(negedge clk);
   endtask

   always @(posedge clk) begin
      due <= Reset_n && frame_clk && !fc_prev;
      fc_prev <= Reset_n ? frame_clk : 1'b0;
   end

   always @(negedge clk) begin
      exp_t e;
      if (due) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_frame: got an update, expected none queued");
         end else begin
            e = q.pop_front();
            check("sb_x", int'(ball_x), e.x);
            check("sb_y", int'(ball_y), e.y);
            check("sb_state", int'(outstate), e.s);
         end
      end
   end

   initial begin
      int r, key;
      null_plat();
      repeat (3) @(negedge clk);
      check("rst_x", int'(ball_x), 320);
      check("rst_y", int'(ball_y), 400);
      check("rst_state", int'(outstate), 0);
      check("ball_size", int'(ball_size), 4);
      Reset_n = 1'b1;
      model_reset();
      for (int i = 0; i < 10; i++) frame(i % 3 == 0 ? 'h04 : i % 3 == 1 ? 'h07 : 0, 1);
      check("idle_x", int'(ball_x), 320);
      check("idle_y", int'(ball_y), 400);
      check("idle_state", int'(outstate), 0);
      frame('h2C, 1);
      check("rise1_y", int'(ball_y), 400);
      check("rise1_state", int'(outstate), 1);
      frame(0, 1);
      check("rise2_y", int'(ball_y), 388);
      frame(0, 1);
      check("rise3_y", int'(ball_y), 377);
      for (int i = 4; i <= 12; i++) frame(0, 1);
      check("rise12_state", int'(outstate), 1);
      frame(0, 1);
      check("rise13_state", int'(outstate), 2);
      for (int i = 0; i < 100 && ms != 3; i++) frame(0, 1);
      check("dead_state", int'(outstate), 3);
      for (int i = 0; i < 3; i++) frame('h04, 1);
      frame('h2C, 1);
      check("restart_x", int'(ball_x), 320);
      check("restart_y", int'(ball_y), 400);
      check("restart_state", int'(outstate), 0);
      // a platform spanning the whole screen under the start point keeps the player bouncing
      px[0] = 320; py[0] = 804; ps = 400;
      apply_plat();
      frame('h2C, 1);
      for (int i = 0; i < 159; i++) frame('h04, 1);
      check("wrap_left_x", int'(ball_x), 635);
      frame('h04, 1);
      check("step_633_x", int'(ball_x), 633);
      frame('h07, 1);
      check("step_635_x", int'(ball_x), 635);
      frame('h07, 1);
      check("wrap_right_x", int'(ball_x), 4);
      for (int i = 0; i < 3; i++) begin
         frame(0, 5);
         check("held_x", int'(ball_x), mx);
         check("held_y", int'(ball_y), my);
         check("held_state", int'(outstate), ms);
      end
      @(negedge clk);
      Reset_n = 1'b0;
      frame_clk = 1'b1;
      keycode = 8'h2C;
      @(negedge clk);
      check("rst_tick_x", int'(ball_x), 320);
      check("rst_tick_y", int'(ball_y), 400);
      check("rst_tick_state", int'(outstate), 0);
      frame_clk = 1'b0;
      @(negedge clk);
      Reset_n = 1'b1;
      model_reset();
      frame(0, 1);
      for (int i = 0; i < 600; i++) begin
         if (i % 25 == 0) begin
            for (int j = 0; j < 4; j++) begin
               px[j] = int'($urandom_range(0, 639));
               py[j] = int'($urandom_range(150, 470));
            end
            ps = int'($urandom_range(2, 30));
            apply_plat();
         end
         r = int'($urandom_range(0, 9));
         key = r < 3 ? 'h04 : r < 6 ? 'h07 : r == 6 ? 'h2C : r == 7 ? int'($urandom_range(0, 255)) : 0;
         frame(key, int'($urandom_range(1, 3)));
      end
      repeat (4) @(negedge clk);
      check("queue_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
